// File: rtl/alu_rs_if.sv
// Dispatch / CDB / issue bundle for the ALU reservation station.
// master = dispatch+CDB side (drives ops and broadcasts), slave = the station.
interface alu_rs_if #(
  parameter int ROB_SIZE_BIT = 4,
  parameter int TYPE_BIT     = 5
);
  logic                    rdy_in;
  logic                    clear;
  logic                    inst_valid;
  logic [TYPE_BIT-1:0]     inst_type;
  logic [ROB_SIZE_BIT-1:0] inst_rob_id;
  logic [31:0]             inst_r1_val;
  logic [31:0]             inst_r2_val;
  logic                    inst_r1_dep;
  logic                    inst_r2_dep;
  logic [ROB_SIZE_BIT-1:0] inst_r1_rob;
  logic [ROB_SIZE_BIT-1:0] inst_r2_rob;
  logic                    rs_full;
  logic                    cdb_alu_valid;
  logic [ROB_SIZE_BIT-1:0] cdb_alu_rob_id;
  logic [31:0]             cdb_alu_val;
  logic                    cdb_lsb_valid;
  logic [ROB_SIZE_BIT-1:0] cdb_lsb_rob_id;
  logic [31:0]             cdb_lsb_val;
  logic                    alu_input;
  logic [TYPE_BIT-1:0]     alu_type;
  logic [31:0]             alu_r1_val;
  logic [31:0]             alu_r2_val;
  logic [ROB_SIZE_BIT-1:0] alu_rob_id;

  modport master (
    output rdy_in, clear, inst_valid, inst_type, inst_rob_id,
           inst_r1_val, inst_r2_val, inst_r1_dep, inst_r2_dep, inst_r1_rob, inst_r2_rob,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_val,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_val,
    input  rs_full, alu_input, alu_type, alu_r1_val, alu_r2_val, alu_rob_id
  );

  modport slave (
    input  rdy_in, clear, inst_valid, inst_type, inst_rob_id,
           inst_r1_val, inst_r2_val, inst_r1_dep, inst_r2_dep, inst_r1_rob, inst_r2_rob,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_val,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_val,
    output rs_full, alu_input, alu_type, alu_r1_val, alu_r2_val, alu_rob_id
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands arrive on the ALU/LSB CDBs, issues one per cycle.
// Define ALU_RS_WAKEUP_EN to let an entry woken by the CDB issue at the same edge (value forwarded).
module alu_rs #(
  parameter int RS_SIZE_BIT  = 3,
  parameter int ROB_SIZE_BIT = 4,
  parameter int TYPE_BIT     = 5
) (
  input logic    clk_in,
  input logic    rst_n_in,
  alu_rs_if.slave bus
);
  localparam int RS_SIZE = 1 << RS_SIZE_BIT;

  // Resolve one operand against both buses; the ALU bus wins when both carry the same tag.
  function automatic logic [32:0] snoop(
    input logic                    dep,
    input logic [ROB_SIZE_BIT-1:0] tag,
    input logic [31:0]             val,
    input logic                    a_vld,
    input logic [ROB_SIZE_BIT-1:0] a_tag,
    input logic [31:0]             a_val,
    input logic                    l_vld,
    input logic [ROB_SIZE_BIT-1:0] l_tag,
    input logic [31:0]             l_val
  );
    logic [32:0] res;
    if (dep && a_vld && (a_tag == tag)) begin
      res = {1'b0, a_val};
    end else if (dep && l_vld && (l_tag == tag)) begin
      res = {1'b0, l_val};
    end else begin
      res = {dep, val};
    end
    return res;
  endfunction

  logic [RS_SIZE-1:0]      valid_q,  valid_d;
  logic [RS_SIZE-1:0]      r1_dep_q, r1_dep_d, r1_dep_s;
  logic [RS_SIZE-1:0]      r2_dep_q, r2_dep_d, r2_dep_s;
  logic [TYPE_BIT-1:0]     type_q   [RS_SIZE];
  logic [TYPE_BIT-1:0]     type_d   [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] rob_q    [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] rob_d    [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r1_rob_q [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r1_rob_d [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r2_rob_q [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r2_rob_d [RS_SIZE];
  logic [31:0]             r1_val_q [RS_SIZE];
  logic [31:0]             r1_val_d [RS_SIZE];
  logic [31:0]             r1_val_s [RS_SIZE];
  logic [31:0]             r2_val_q [RS_SIZE];
  logic [31:0]             r2_val_d [RS_SIZE];
  logic [31:0]             r2_val_s [RS_SIZE];

  logic                    alu_input_q,  alu_input_d;
  logic [TYPE_BIT-1:0]     alu_type_q,   alu_type_d;
  logic [31:0]             alu_r1_val_q, alu_r1_val_d;
  logic [31:0]             alu_r2_val_q, alu_r2_val_d;
  logic [ROB_SIZE_BIT-1:0] alu_rob_id_q, alu_rob_id_d;

  logic [RS_SIZE-1:0]      ready_s;
  logic                    issue_hit_s, free_hit_s, rs_full_s;
  logic [RS_SIZE_BIT-1:0]  issue_idx_s, free_idx_s;
  logic                    in_r1_dep_s, in_r2_dep_s;
  logic [31:0]             in_r1_val_s, in_r2_val_s;

  assign rs_full_s      = &valid_q;
  assign bus.rs_full    = rs_full_s;
  assign bus.alu_input  = alu_input_q;
  assign bus.alu_type   = alu_type_q;
  assign bus.alu_r1_val = alu_r1_val_q;
  assign bus.alu_r2_val = alu_r2_val_q;
  assign bus.alu_rob_id = alu_rob_id_q;

  // Operand snoop, issue/free slot selection and next-state for entries and issue registers.
  always_comb begin
    valid_d      = valid_q;
    r1_dep_d     = r1_dep_q;
    r2_dep_d     = r2_dep_q;
    type_d       = type_q;
    rob_d        = rob_q;
    r1_rob_d     = r1_rob_q;
    r2_rob_d     = r2_rob_q;
    r1_val_d     = r1_val_q;
    r2_val_d     = r2_val_q;
    alu_input_d  = alu_input_q;
    alu_type_d   = alu_type_q;
    alu_r1_val_d = alu_r1_val_q;
    alu_r2_val_d = alu_r2_val_q;
    alu_rob_id_d = alu_rob_id_q;

    for (int i = 0; i < RS_SIZE; i++) begin
      {r1_dep_s[i], r1_val_s[i]} = snoop(r1_dep_q[i], r1_rob_q[i], r1_val_q[i],
          bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_val,
          bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_val);
      {r2_dep_s[i], r2_val_s[i]} = snoop(r2_dep_q[i], r2_rob_q[i], r2_val_q[i],
          bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_val,
          bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_val);
    end
    {in_r1_dep_s, in_r1_val_s} = snoop(bus.inst_r1_dep, bus.inst_r1_rob, bus.inst_r1_val,
        bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_val,
        bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_val);
    {in_r2_dep_s, in_r2_val_s} = snoop(bus.inst_r2_dep, bus.inst_r2_rob, bus.inst_r2_val,
        bus.cdb_alu_valid, bus.cdb_alu_rob_id, bus.cdb_alu_val,
        bus.cdb_lsb_valid, bus.cdb_lsb_rob_id, bus.cdb_lsb_val);

`ifdef ALU_RS_WAKEUP_EN
    ready_s = valid_q & ~r1_dep_s & ~r2_dep_s;
`else
    ready_s = valid_q & ~r1_dep_q & ~r2_dep_q;
`endif

    // Scan high-to-low so the lowest index is the one left standing.
    issue_hit_s = 1'b0;
    issue_idx_s = {RS_SIZE_BIT{1'b0}};
    free_hit_s  = 1'b0;
    free_idx_s  = {RS_SIZE_BIT{1'b0}};
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      issue_hit_s = issue_hit_s | ready_s[i];
      issue_idx_s = ready_s[i] ? RS_SIZE_BIT'(i) : issue_idx_s;
      free_hit_s  = free_hit_s | ~valid_q[i];
      free_idx_s  = ~valid_q[i] ? RS_SIZE_BIT'(i) : free_idx_s;
    end

    if (!bus.rdy_in) begin
      alu_input_d = alu_input_q;
    end else if (bus.clear) begin
      valid_d     = {RS_SIZE{1'b0}};
      alu_input_d = 1'b0;
    end else begin
      r1_dep_d = r1_dep_s;
      r2_dep_d = r2_dep_s;
      r1_val_d = r1_val_s;
      r2_val_d = r2_val_s;
      if (issue_hit_s) begin
        valid_d[issue_idx_s] = 1'b0;
        alu_input_d          = 1'b1;
        alu_type_d           = type_q[issue_idx_s];
        alu_r1_val_d         = r1_val_s[issue_idx_s];
        alu_r2_val_d         = r2_val_s[issue_idx_s];
        alu_rob_id_d         = rob_q[issue_idx_s];
      end else begin
        alu_input_d = 1'b0;
      end
      // Free slot comes from pre-issue occupancy, so an issued slot is never refilled at the same edge.
      if (bus.inst_valid && free_hit_s) begin
        valid_d[free_idx_s]  = 1'b1;
        type_d[free_idx_s]   = bus.inst_type;
        rob_d[free_idx_s]    = bus.inst_rob_id;
        r1_rob_d[free_idx_s] = bus.inst_r1_rob;
        r2_rob_d[free_idx_s] = bus.inst_r2_rob;
        r1_dep_d[free_idx_s] = in_r1_dep_s;
        r2_dep_d[free_idx_s] = in_r2_dep_s;
        r1_val_d[free_idx_s] = in_r1_val_s;
        r2_val_d[free_idx_s] = in_r2_val_s;
      end else begin
        valid_d[free_idx_s] = valid_d[free_idx_s];
      end
    end
  end

  // State and issue registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q      <= {RS_SIZE{1'b0}};
      r1_dep_q     <= {RS_SIZE{1'b0}};
      r2_dep_q     <= {RS_SIZE{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        type_q[i]   <= {TYPE_BIT{1'b0}};
        rob_q[i]    <= {ROB_SIZE_BIT{1'b0}};
        r1_rob_q[i] <= {ROB_SIZE_BIT{1'b0}};
        r2_rob_q[i] <= {ROB_SIZE_BIT{1'b0}};
        r1_val_q[i] <= 32'd0;
        r2_val_q[i] <= 32'd0;
      end
      alu_input_q  <= 1'b0;
      alu_type_q   <= {TYPE_BIT{1'b0}};
      alu_r1_val_q <= 32'd0;
      alu_r2_val_q <= 32'd0;
      alu_rob_id_q <= {ROB_SIZE_BIT{1'b0}};
    end else begin
      valid_q      <= valid_d;
      r1_dep_q     <= r1_dep_d;
      r2_dep_q     <= r2_dep_d;
      type_q       <= type_d;
      rob_q        <= rob_d;
      r1_rob_q     <= r1_rob_d;
      r2_rob_q     <= r2_rob_d;
      r1_val_q     <= r1_val_d;
      r2_val_q     <= r2_val_d;
      alu_input_q  <= alu_input_d;
      alu_type_q   <= alu_type_d;
      alu_r1_val_q <= alu_r1_val_d;
      alu_r2_val_q <= alu_r2_val_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against a slot-array model.
module tb_alu_rs;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_rs_if #(.ROB_SIZE_BIT(4), .TYPE_BIT(5)) bus ();

  alu_rs #(.RS_SIZE_BIT(3), .ROB_SIZE_BIT(4), .TYPE_BIT(5)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [4:0]  ty;
    logic [3:0]  rob;
    logic [31:0] a, b;
    bit          da, db;
    logic [3:0]  ta, tb;
  } ent_t;

  ent_t        m [8];
  logic        e_in;
  logic [4:0]  e_ty;
  logic [31:0] e_a, e_b;
  logic [3:0]  e_rob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] rslv(input bit d, input logic [3:0] t, input logic [31:0] v);
    if (d && bus.cdb_alu_valid && bus.cdb_alu_rob_id == t) return {1'b0, bus.cdb_alu_val};
    if (d && bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == t) return {1'b0, bus.cdb_lsb_val};
    return {d, v};
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 8; i++) if (!m[i].v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = '{default: '0};
    e_in = 1'b0; e_ty = 5'd0; e_a = 32'd0; e_b = 32'd0; e_rob = 4'd0;
  endtask

  // One clock edge of the station's behaviour, applied to the model.
  task automatic model_step();
    ent_t nx [8];
    int   k;
    int   j;
    bit   rd;
    if (!bus.rdy_in) return;
    if (bus.clear) begin
      for (int i = 0; i < 8; i++) m[i].v = 1'b0;
      e_in = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      nx[i] = m[i];
      {nx[i].da, nx[i].a} = rslv(m[i].da, m[i].ta, m[i].a);
      {nx[i].db, nx[i].b} = rslv(m[i].db, m[i].tb, m[i].b);
    end
    k = -1;
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_RS_WAKEUP_EN
      rd = m[i].v && !nx[i].da && !nx[i].db;
`else
      rd = m[i].v && !m[i].da && !m[i].db;
`endif
      if (k < 0 && rd) k = i;
    end
    if (k >= 0) begin
      e_in = 1'b1; e_ty = nx[k].ty; e_a = nx[k].a; e_b = nx[k].b; e_rob = nx[k].rob;
      nx[k].v = 1'b0;
    end else begin
      e_in = 1'b0;
    end
    j = -1;
    for (int i = 0; i < 8; i++) if (j < 0 && !m[i].v) j = i;
    if (bus.inst_valid && j >= 0) begin
      nx[j].v = 1'b1; nx[j].ty = bus.inst_type; nx[j].rob = bus.inst_rob_id;
      nx[j].ta = bus.inst_r1_rob; nx[j].tb = bus.inst_r2_rob;
      {nx[j].da, nx[j].a} = rslv(bus.inst_r1_dep, bus.inst_r1_rob, bus.inst_r1_val);
      {nx[j].db, nx[j].b} = rslv(bus.inst_r2_dep, bus.inst_r2_rob, bus.inst_r2_val);
    end
    m = nx;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_input"}, 32'(bus.alu_input), 32'(e_in));
    chk({tag, "_type"},  32'(bus.alu_type),  32'(e_ty));
    chk({tag, "_r1"},    bus.alu_r1_val,     e_a);
    chk({tag, "_r2"},    bus.alu_r2_val,     e_b);
    chk({tag, "_rob"},   32'(bus.alu_rob_id), 32'(e_rob));
    chk({tag, "_full"},  32'(bus.rs_full),   32'(model_full()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    bus.inst_valid = 1'b0; bus.clear = 1'b0;
    bus.cdb_alu_valid = 1'b0; bus.cdb_lsb_valid = 1'b0;
  endtask

  task automatic put(input logic [4:0] ty, input logic [3:0] rob, input logic [31:0] a,
                     input logic [31:0] b, input bit d1, input logic [3:0] t1,
                     input bit d2, input logic [3:0] t2);
    bus.inst_valid = 1'b1; bus.inst_type = ty; bus.inst_rob_id = rob;
    bus.inst_r1_val = a; bus.inst_r2_val = b;
    bus.inst_r1_dep = d1; bus.inst_r1_rob = t1; bus.inst_r2_dep = d2; bus.inst_r2_rob = t2;
  endtask

  initial begin
    int          nxt;
    logic [3:0]  seq [2];
    logic        snap_in;
    logic [3:0]  snap_rob;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.rdy_in = 1'b1;
    idle();
    put(5'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    bus.inst_valid = 1'b0;
    bus.cdb_alu_rob_id = 4'd0; bus.cdb_alu_val = 32'd0;
    bus.cdb_lsb_rob_id = 4'd0; bus.cdb_lsb_val = 32'd0;
    model_reset();
    @(posedge clk); #1;
    compare_all("reset");
    rst_n = 1'b1;

    // 1: dependency-free ADD issues one edge after dispatch.
    put(5'd0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    step("t1_disp");
    chk("t1_no_early", 32'(bus.alu_input), 32'd0);
    idle();
    step("t1_issue");
    chk("t1_in", 32'(bus.alu_input), 32'd1);
    chk("t1_sum", bus.alu_r1_val + bus.alu_r2_val, 32'd12);
    chk("t1_rob", 32'(bus.alu_rob_id), 32'd3);

    // 2: SUB waiting on rob 2, woken by ALU CDB.
    put(5'd1, 4'd4, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0);
    step("t2_disp");
    idle();
    bus.cdb_alu_valid = 1'b1; bus.cdb_alu_rob_id = 4'd2; bus.cdb_alu_val = 32'h10;
    step("t2_cdb");
`ifdef ALU_RS_WAKEUP_EN
    chk("t2_wake_in", 32'(bus.alu_input), 32'd1);
`else
    chk("t2_wait_in", 32'(bus.alu_input), 32'd0);
`endif
    idle();
    step("t2_next");
    chk("t2_r1", bus.alu_r1_val, 32'h10);
    chk("t2_type", 32'(bus.alu_type), 32'd1);

    // 3: fill all 8 slots on rob 9, 9th dispatch ignored, LSB wakes all in slot order.
    for (int i = 0; i < 8; i++) begin
      put(5'(i + 8), 4'(i), 32'd0, 32'(i * 3), 1'b1, 4'd9, 1'b0, 4'd0);
      step("t3_fill");
    end
    chk("t3_full", 32'(bus.rs_full), 32'd1);
    put(5'd31, 4'd15, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    step("t3_ovf");
    idle();
    bus.cdb_lsb_valid = 1'b1; bus.cdb_lsb_rob_id = 4'd9; bus.cdb_lsb_val = 32'hABCD;
    nxt = 0;
    for (int c = 0; c < 11; c++) begin
      step("t3_drain");
      idle();
      if (bus.alu_input) begin
        chk("t3_order", 32'(bus.alu_rob_id), 32'(nxt));
        chk("t3_val", bus.alu_r1_val, 32'hABCD);
        nxt++;
      end
    end
    chk("t3_count", 32'(nxt), 32'd8);

    // 4: slots 1 and 5 woken together; lower slot first.
    for (int i = 0; i < 6; i++) begin
      put(5'd2, 4'(10 + i), 32'd0, 32'd1, 1'b1, (i == 1 || i == 5) ? 4'd1 : 4'd6, 1'b0, 4'd0);
      step("t4_fill");
    end
    idle();
    bus.cdb_alu_valid = 1'b1; bus.cdb_alu_rob_id = 4'd1; bus.cdb_alu_val = 32'h44;
    nxt = 0;
    for (int c = 0; c < 4; c++) begin
      step("t4_run");
      idle();
      if (bus.alu_input && nxt < 2) begin seq[nxt] = bus.alu_rob_id; nxt++; end
    end
    chk("t4_count", 32'(nxt), 32'd2);
    chk("t4_first", 32'(seq[0]), 32'd11);
    chk("t4_second", 32'(seq[1]), 32'd15);

    // 5: clear with four entries held, with a same-cycle dispatch that must be dropped.
    bus.clear = 1'b1;
    put(5'd3, 4'd7, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    step("t5_clear");
    chk("t5_clr_in", 32'(bus.alu_input), 32'd0);
    chk("t5_clr_full", 32'(bus.rs_full), 32'd0);
    idle();
    bus.cdb_alu_valid = 1'b1; bus.cdb_alu_rob_id = 4'd6; bus.cdb_alu_val = 32'h66;
    for (int c = 0; c < 3; c++) begin
      step("t5_after");
      chk("t5_no_issue", 32'(bus.alu_input), 32'd0);
    end
    idle();

    // 5b: rdy low freezes a ready entry for three cycles.
    put(5'd4, 4'd7, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    step("t5b_disp");
    idle();
    bus.rdy_in = 1'b0;
    snap_in = bus.alu_input; snap_rob = bus.alu_rob_id;
    for (int c = 0; c < 3; c++) begin
      step("t5b_frozen");
      chk("t5b_in_hold", 32'(bus.alu_input), 32'(snap_in));
      chk("t5b_rob_hold", 32'(bus.alu_rob_id), 32'(snap_rob));
    end
    bus.rdy_in = 1'b1;
    step("t5b_resume");
    chk("t5b_in", 32'(bus.alu_input), 32'd1);
    chk("t5b_rob", 32'(bus.alu_rob_id), 32'd7);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.rdy_in = ($urandom_range(7) != 0);
      bus.clear  = ($urandom_range(49) == 0);
      put(5'($urandom), 4'($urandom), $urandom, $urandom,
          1'($urandom), 4'($urandom_range(3)), 1'($urandom), 4'($urandom_range(3)));
      bus.inst_valid     = 1'($urandom);
      bus.cdb_alu_valid  = 1'($urandom);
      bus.cdb_alu_rob_id = 4'($urandom_range(3));
      bus.cdb_alu_val    = $urandom;
      bus.cdb_lsb_valid  = 1'($urandom);
      bus.cdb_lsb_rob_id = 4'($urandom_range(3));
      bus.cdb_lsb_val    = $urandom;
      step("rand");
    end

    // 6: async reset mid-stream acts immediately; nothing stale issues afterwards.
    idle();
    bus.rdy_in = 1'b1;
    put(5'd9, 4'd5, 32'd8, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    step("t6_disp");
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async");
    @(posedge clk); #1;
    compare_all("t6_held");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.cdb_alu_valid = 1'b1; bus.cdb_alu_rob_id = 4'(c); bus.cdb_alu_val = 32'hDEAD;
      step("t6_post");
      chk("t6_no_stale", 32'(bus.alu_input), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
